// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state type and default sizing for the iterative Booth multiplier.
package booth_pkg;
    localparam int DEF_WIDTH = 25;
    localparam int DEF_TAG_W = 10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (conditional add/subtract, then arithmetic shift of {A,Q,q_m1}).
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH:0]   q_i,
    input  logic             q_m1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] a_o,
    output logic [WIDTH:0]   q_o,
    output logic             q_m1_o
);
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    always_comb begin
        m_ext  = {m_i[WIDTH], m_i};
        sum    = ({q_i[0], q_m1_i} == 2'b01) ? a_i + m_ext :
                 ({q_i[0], q_m1_i} == 2'b10) ? a_i - m_ext : a_i;
        a_o    = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_o    = {sum[0], q_i[WIDTH:1]};
        q_m1_o = q_i[0];
    end
endmodule

// File: rtl/booth_mult_iter.sv
// booth_mult_iter: iterative radix-2 Booth multiplier, signed or unsigned, WIDTH+1 fixed steps per product.
module booth_mult_iter
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               is_signed,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [TAG_W-1:0]   tag_o
);
    localparam int CW = $clog2(WIDTH + 2);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH+1:0] a_q, a_d, step_a;
    logic [WIDTH:0]   q_q, q_d, step_q;
    logic [WIDTH:0]   m_q, m_d;
    logic             q_m1_q, q_m1_d, step_q_m1;
    logic [TAG_W-1:0] tag_q, tag_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i    (a_q),
        .q_i    (q_q),
        .q_m1_i (q_m1_q),
        .m_i    (m_q),
        .a_o    (step_a),
        .q_o    (step_q),
        .q_m1_o (step_q_m1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        q_m1_d  = q_m1_q;
        m_d     = m_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                cnt_d   = '0;
                a_d     = '0;
                q_m1_d  = 1'b0;
                m_d     = {is_signed & multiplicand[WIDTH-1], multiplicand};
                q_d     = {is_signed & multiplier[WIDTH-1], multiplier};
                tag_d   = tag_i;
            end
            RUN: begin
                a_d     = step_a;
                q_d     = step_q;
                q_m1_d  = step_q_m1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH)) ? DONE : RUN;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            m_q     <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q_m1_q  <= q_m1_d;
            m_q     <= m_d;
            tag_q   <= tag_d;
        end
    end

    // the low 2*WIDTH bits of {A,Q} already hold the exact product for both modes
    assign product   = {a_q[WIDTH-2:0], q_q};
    assign tag_o     = tag_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
endmodule

// File: tb/tb_booth_mult_iter.sv
// tb_booth_mult_iter: randomized and directed checks of booth_mult_iter at WIDTH=8 and WIDTH=25.
module tb_booth_mult_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    logic        iv8 = 1'b0, or8 = 1'b1, s8 = 1'b0, ir8, ov8;
    logic [7:0]  m8 = '0, q8 = '0;
    logic [9:0]  tag8 = '0, to8;
    logic [15:0] p8;

    logic        iv25 = 1'b0, or25 = 1'b1, s25 = 1'b0, ir25, ov25;
    logic [24:0] m25 = '0, q25 = '0;
    logic [9:0]  tag25 = '0, to25;
    logic [49:0] p25;

    booth_mult_iter #(.WIDTH(8), .TAG_W(10)) dut8 (
        .clk(clk), .reset(rst_n), .in_valid(iv8), .in_ready(ir8),
        .multiplicand(m8), .multiplier(q8), .is_signed(s8), .tag_i(tag8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .tag_o(to8)
    );

    booth_mult_iter #(.WIDTH(25), .TAG_W(10)) dut25 (
        .clk(clk), .reset(rst_n), .in_valid(iv25), .in_ready(ir25),
        .multiplicand(m25), .multiplier(q25), .is_signed(s25), .tag_i(tag25),
        .out_valid(ov25), .out_ready(or25), .product(p25), .tag_o(to25)
    );

    // reference: interpret operands as integers per mode, multiply, keep low 2w bits
    function automatic longint ref_mul(int w, longint a, longint b, bit s);
        longint x, y, p, mask;
        mask = (longint'(1) << w) - 1;
        x = a & mask;
        y = b & mask;
        if (s && x[w-1]) x = x - (longint'(1) << w);
        if (s && y[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [9:0] t, output int lat);
        int g;
        g = 0;
        while (!ir8 && g < 100) begin @(posedge clk); #1; g++; end
        m8 = a; q8 = b; s8 = s; tag8 = t; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #13;
        chk_cnt++;
        if ({ir8, ov8, p8, to8} !== {1'b1, 1'b0, 16'h0, 10'h0})
            $display("FAIL reset_in: ir=%b ov=%b p=%h tag=%h, want 1 0 0000 000", ir8, ov8, p8, to8);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if ({ir8, ov8, p8, ir25, ov25, p25} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 50'h0})
            $display("FAIL reset_out: ir8=%b ov8=%b p8=%h ir25=%b ov25=%b p25=%h, want idle zeros",
                     ir8, ov8, p8, ir25, ov25, p25);
        else pass_cnt++;
    endtask

    task automatic test_known;
        logic [7:0]  av [4] = '{8'h07, 8'hFF, 8'h80, 8'hFF};
        logic [7:0]  bv [4] = '{8'hFD, 8'hFF, 8'h80, 8'hFF};
        logic        sv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] ev [4] = '{16'hFFEB, 16'hFE01, 16'h4000, 16'h0001};
        int lat;
        or8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op8(av[i], bv[i], sv[i], 10'(i + 100), lat);
            chk_cnt++;
            if (lat !== 9) $display("FAIL known%0d_latency: got %0d edges, want 9", i, lat);
            else pass_cnt++;
            chk_cnt++;
            if (p8 !== ev[i]) $display("FAIL known%0d_product: got %h, want %h", i, p8, ev[i]);
            else pass_cnt++;
            chk_cnt++;
            if (to8 !== 10'(i + 100)) $display("FAIL known%0d_tag: got %0d, want %0d", i, to8, i + 100);
            else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        int g;
        logic [15:0] exp_p;
        exp_p = 16'(ref_mul(8, 64'h9C, 64'h35, 1'b1));
        or8 = 1'b0;
        g = 0;
        while (!ir8 && g < 100) begin @(posedge clk); #1; g++; end
        m8 = 8'h9C; q8 = 8'h35; s8 = 1'b1; tag8 = 10'h2A5; iv8 = 1'b1;
        @(posedge clk); #1;
        g = 0;
        while (!ov8 && g < 40) begin
            m8 = 8'($urandom()); q8 = 8'($urandom()); s8 = 1'($urandom()); tag8 = 10'($urandom());
            @(posedge clk); #1; g++;
        end
        iv8 = 1'b0;
        chk_cnt++;
        if (!ov8 || p8 !== exp_p || to8 !== 10'h2A5)
            $display("FAIL stall_result: ov=%b p=%h tag=%h, want 1 %h 2a5", ov8, p8, to8, exp_p);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if ({ov8, ir8, p8, to8} !== {1'b1, 1'b0, exp_p, 10'h2A5})
                $display("FAIL stall_hold%0d: ov=%b ir=%b p=%h tag=%h, want 1 0 %h 2a5", c, ov8, ir8, p8, to8, exp_p);
            else pass_cnt++;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if ({ov8, ir8} !== 2'b01)
            $display("FAIL stall_release: ov=%b ir=%b, want 0 1", ov8, ir8);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run;
        int lat;
        bit seen;
        m8 = 8'hD3; q8 = 8'h6B; s8 = 1'b1; tag8 = 10'h111; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({ir8, ov8, p8, to8} !== {1'b1, 1'b0, 16'h0, 10'h0})
            $display("FAIL midrun_async: ir=%b ov=%b p=%h tag=%h, want 1 0 0000 000", ir8, ov8, p8, to8);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (ov8 || !ir8) seen = 1'b1; end
        chk_cnt++;
        if (seen) $display("FAIL midrun_discard: got ov/ir activity after release, want idle");
        else pass_cnt++;
        op8(8'd3, 8'd5, 1'b0, 10'h05, lat);
        chk_cnt++;
        if (p8 !== 16'h000F || lat !== 9)
            $display("FAIL midrun_next: got p=%h lat=%0d, want 000f 9", p8, lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        localparam int N = 40;
        logic [49:0] exp_p [$];
        logic [9:0]  exp_t [$];
        int got, cyc, last, bad_order;
        bit was_ready;
        int g;
        logic [24:0] pick [4] = '{25'h1000000, 25'h1FFFFFF, 25'h0FFFFFF, 25'h0};
        or25 = 1'b1;
        got = 0;
        bad_order = 0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    m25 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 25'($urandom());
                    q25 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 25'($urandom());
                    s25 = 1'($urandom());
                    tag25 = 10'(i);
                    iv25 = 1'b1;
                    g = 0;
                    do begin
                        was_ready = ir25;
                        @(posedge clk); #1; g++;
                    end while (!was_ready && g < 200);
                    exp_p.push_back(50'(ref_mul(25, longint'(m25), longint'(q25), s25)));
                    exp_t.push_back(10'(i));
                end
                iv25 = 1'b0;
            end
            begin
                cyc = 0;
                last = -1;
                while (got < N && cyc < N * 40) begin
                    @(posedge clk); #1; cyc++;
                    if (ov25) begin
                        chk_cnt++;
                        if (exp_p.size() == 0) begin
                            $display("FAIL b2b_unexpected: result %h with no pending op", p25);
                        end else begin
                            logic [49:0] ep;
                            logic [9:0]  et;
                            ep = exp_p.pop_front();
                            et = exp_t.pop_front();
                            if (p25 !== ep || to25 !== et)
                                $display("FAIL b2b_op%0d: got p=%h tag=%0d, want p=%h tag=%0d", got, p25, to25, ep, et);
                            else pass_cnt++;
                        end
                        if (last >= 0 && cyc - last != 28) bad_order++;
                        last = cyc;
                        got++;
                    end
                end
            end
        join
        chk_cnt++;
        if (got !== N) $display("FAIL b2b_count: got %0d results, want %0d", got, N);
        else pass_cnt++;
        chk_cnt++;
        if (bad_order !== 0) $display("FAIL b2b_cadence: %0d result gaps differ from 28 cycles", bad_order);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_known();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/booth_mult_iter.md
BOOTH_MULT_ITER -- requirements
Module: booth_mult_iter

Interface
REQ-001 Parameter WIDTH, 25, operand width in bits (minimum 4).
REQ-002 Parameter TAG_W, 10, width of sideband tag (sign/exponent passthrough).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and tag valid.
REQ-006 in_ready  output  1  unit idle and able to accept.
REQ-007 multiplicand  input  WIDTH  operand M.
REQ-008 multiplier  input  WIDTH  operand Q.
REQ-009 is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-010 tag_i  input  TAG_W  opaque sideband, captured with operands.
REQ-011 out_valid  output  1  product and tag valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 product  output  2*WIDTH  exact product.
REQ-014 tag_o  output  TAG_W  tag captured with the operands producing product.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on in_valid&in_ready; RUN->DONE after the last step; DONE->IDLE on out_valid&out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 On accept, operands SHALL be extended to WIDTH+1 bits (sign-extend if is_signed, else zero-extend); M, Q, tag and mode latched.
REQ-018 Datapath SHALL be radix-2 Booth: accumulator A of WIDTH+2 bits, Q register WIDTH+1 bits, q_m1 bit; A, q_m1 cleared on accept.
REQ-019 Each RUN cycle SHALL examine {Q[0],q_m1}: 01 -> A+=M, 10 -> A-=M, 00/11 -> no add; then arithmetic-shift {A,Q,q_m1} right by one.
REQ-020 Iteration counter SHALL run exactly WIDTH+1 steps, independent of operand values or mode (no early termination).
REQ-021 Latency: out_valid SHALL rise on the (WIDTH+1)th rising edge after the accept edge.
REQ-022 product SHALL equal the low 2*WIDTH bits of {A,Q} after the final step; result exact for all operand pairs, including most-negative x most-negative.
REQ-023 product and tag_o SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 Input operand changes while not in IDLE SHALL have no effect.
REQ-025 After the output handshake, one IDLE cycle SHALL precede the next accept (throughput 1 result per WIDTH+3 cycles).
REQ-026 in_valid asserted with in_ready=0 SHALL not be queued; the source must hold it.

Reset
REQ-027 reset low SHALL force, asynchronously, state=IDLE, counter=0, A/Q/M/q_m1=0, product=0, tag_o=0, out_valid=0, in_ready=1 after deassert.
REQ-028 reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid for it after release.

Structure
REQ-029 Shared package booth_pkg SHALL hold the FSM state enum and default WIDTH/TAG_W constants.
REQ-030 One combinational sub-module booth_step SHALL implement a single add/subtract/shift iteration (REQ-019), parametrised by WIDTH.
REQ-031 Counter width SHALL be $clog2(WIDTH+2) bits.

Verification (WIDTH=8 unless stated)
REQ-032 signed 7 x -3 (8'h07, 8'hFD) -> product 16'hFFEB, out_valid 9 edges after accept.
REQ-033 unsigned 8'hFF x 8'hFF -> 16'hFE01; signed 8'h80 x 8'h80 -> 16'h4000; signed 8'hFF x 8'hFF -> 16'h0001.
REQ-034 out_ready held low 5 cycles after out_valid -> product, tag_o stable, in_ready=0 throughout; release -> IDLE next edge.
REQ-035 reset pulsed at step 4 of RUN -> out_valid=0, in_ready=1 after release, next op (3 x 5) yields 16'h000F.
REQ-036 back-to-back random signed/unsigned ops, WIDTH=25, tag = op index -> every product matches reference model, tags in order.
